pool_upsample: RTL and testbench



---
 rtl/pool_upsample.sv | 197 +++++++++++++++++++
 tb/tb_pool_upsample.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool_upsample.sv
// pool_upsample: nearest-neighbour unpooling stage.
// Stores one pooled row of ROW_WORDS vectors, then emits it POOL_X times
// horizontally and POOL_Y times vertically in the same NUM_PE-wide format.
// Optional macro UPSAMPLE_ZERO_FILL_EN: max-unpool zero insertion instead of
// replication (source value only at the top-left of each POOL_X x POOL_Y cell).
module pool_upsample #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned POOL_X     = 2,
  parameter int unsigned POOL_Y     = 2,
  parameter int unsigned ROW_WORDS  = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         ENABLE,
  output logic                         READY,
  input  logic [DATA_WIDTH*NUM_PE-1:0] DATA_IN,
  output logic [DATA_WIDTH*NUM_PE-1:0] DATA_OUT,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY
);

  localparam int unsigned VEC_W = DATA_WIDTH * NUM_PE;
  localparam int unsigned IW    = (VEC_W > 1) ? $clog2(VEC_W) : 1;
  localparam int unsigned XW    = (POOL_X > 1) ? $clog2(POOL_X) : 1;
  localparam int unsigned YW    = (POOL_Y > 1) ? $clog2(POOL_Y) : 1;
  localparam int unsigned WW    = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

  localparam logic [XW-1:0] LAST_X = XW'(POOL_X - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(POOL_Y - 1);
  localparam logic [WW-1:0] LAST_W = WW'(ROW_WORDS - 1);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WW-1:0]    word_q, word_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic             ready_q, ready_d;
  logic [VEC_W-1:0] data_out_q;
  logic [VEC_W-1:0] exp_vec;
  logic             buf_we;
  logic             load_out;
  logic             clr_out;

  logic [VEC_W-1:0] row_buf [ROW_WORDS];

`ifdef UPSAMPLE_ZERO_FILL_EN
  // Output element e takes the source only at the top-left of its pooling cell.
  function automatic logic [VEC_W-1:0] expand(input logic [VEC_W-1:0] src,
                                              input logic [XW-1:0]    x,
                                              input logic [YW-1:0]    y);
    logic [VEC_W-1:0] res;
    int unsigned      pos;
    logic [IW-1:0]    src_lo;
    logic [IW-1:0]    dst_lo;
    res = '0;
    for (int unsigned e = 0; e < NUM_PE; e++) begin
      pos    = 32'(x) * NUM_PE + e;
      src_lo = IW'(DATA_WIDTH * (NUM_PE - 1 - pos / POOL_X));
      dst_lo = IW'(DATA_WIDTH * (NUM_PE - 1 - e));
      if ((y == '0) && ((pos % POOL_X) == 0)) begin
        res[dst_lo +: DATA_WIDTH] = src[src_lo +: DATA_WIDTH];
      end
    end
    return res;
  endfunction

  assign exp_vec = expand(row_buf[word_d], x_d, y_d);
`else
  // Output element e replicates source element (x*NUM_PE + e) / POOL_X.
  function automatic logic [VEC_W-1:0] expand(input logic [VEC_W-1:0] src,
                                              input logic [XW-1:0]    x);
    logic [VEC_W-1:0] res;
    int unsigned      pos;
    logic [IW-1:0]    src_lo;
    logic [IW-1:0]    dst_lo;
    res = '0;
    for (int unsigned e = 0; e < NUM_PE; e++) begin
      pos    = 32'(x) * NUM_PE + e;
      src_lo = IW'(DATA_WIDTH * (NUM_PE - 1 - pos / POOL_X));
      dst_lo = IW'(DATA_WIDTH * (NUM_PE - 1 - e));
      res[dst_lo +: DATA_WIDTH] = src[src_lo +: DATA_WIDTH];
    end
    return res;
  endfunction

  assign exp_vec = expand(row_buf[word_d], x_d);
`endif

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counter advance and output-register control.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    buf_we      = 1'b0;
    load_out    = 1'b0;
    clr_out     = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (ENABLE && ready_q) begin
          buf_we = 1'b1;
          if (word_q == LAST_W) begin
            word_d  = '0;
            state_d = EMIT;
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end
      EMIT: begin
        if (!out_valid_q) begin
          // First vector of the row; counters are already at zero.
          out_valid_d = 1'b1;
          load_out    = 1'b1;
        end else if (OUT_READY) begin
          if (x_q != LAST_X) begin
            x_d      = x_q + XW'(1);
            load_out = 1'b1;
          end else begin
            x_d = '0;
            if (word_q != LAST_W) begin
              word_d   = word_q + WW'(1);
              load_out = 1'b1;
            end else begin
              word_d = '0;
              if (y_q != LAST_Y) begin
                y_d      = y_q + YW'(1);
                load_out = 1'b1;
              end else begin
                y_d         = '0;
                out_valid_d = 1'b0;
                clr_out     = 1'b1;
                state_d     = LOAD;
              end
            end
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
    ready_d = (state_d == LOAD);
  end

  // Counters, handshake flags and the registered output vector.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      word_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      data_out_q  <= '0;
    end else begin
      word_q      <= word_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
      if (clr_out) begin
        data_out_q <= '0;
      end else if (load_out) begin
        data_out_q <= exp_vec;
      end
    end
  end

  // Row buffer; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (buf_we) begin
      row_buf[word_q] <= DATA_IN;
    end
  end

  assign READY     = ready_q;
  assign OUT_VALID = out_valid_q;
  assign DATA_OUT  = data_out_q;

endmodule

// File: tb/tb_pool_upsample.sv
// Scoreboard bench for pool_upsample at default parameters.
module tb_pool_upsample;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        READY;
  logic [63:0] DATA_IN;
  logic [63:0] DATA_OUT;
  logic        OUT_VALID;
  logic        OUT_READY;

  int          total = 0;
  int          bad = 0;
  int          xfers = 0;
  int          vcycles = 0;
  logic        toggle = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic [63:0] exp_q[$];

  localparam logic [15:0] A = 16'hA0A1, B = 16'hB0B2, C = 16'hC0C3, D = 16'hD0D4;
  localparam logic [15:0] E = 16'hE0E5, F = 16'hF0F6, G = 16'h1077, H = 16'h2088;

  pool_upsample dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .READY    (READY),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] v4(input logic [15:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  // Expected upsampled row for inputs {a,b,c,d},{e,f,g,h}.
  task automatic push_row(input logic [15:0] a, b, c, d, e, f, g, h);
    for (int y = 0; y < 2; y++) begin
`ifdef UPSAMPLE_ZERO_FILL_EN
      if (y == 0) begin
        exp_q.push_back(v4(a, 16'h0, b, 16'h0));
        exp_q.push_back(v4(c, 16'h0, d, 16'h0));
        exp_q.push_back(v4(e, 16'h0, f, 16'h0));
        exp_q.push_back(v4(g, 16'h0, h, 16'h0));
      end else begin
        for (int k = 0; k < 4; k++) exp_q.push_back(64'h0);
      end
`else
      exp_q.push_back(v4(a, a, b, b));
      exp_q.push_back(v4(c, c, d, d));
      exp_q.push_back(v4(e, e, f, f));
      exp_q.push_back(v4(g, g, h, h));
`endif
    end
  endtask

  // Present one input vector once READY is seen, for exactly one edge.
  task automatic send(input logic [63:0] v);
    int t = 0;
    while (!READY && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (!READY) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got READY=0 expected READY=1");
    end
    ENABLE  = 1'b1;
    DATA_IN = v;
    @(posedge CLK);
    #1;
    ENABLE = 1'b0;
  endtask

  // Wait until every expected vector has been emitted and OUT_VALID drops.
  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || OUT_VALID) && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    chk("ready_after_row", 64'(READY), 64'd1);
  endtask

  // OUT_READY toggling used by the back-pressure test.
  always @(posedge CLK) begin
    if (toggle) begin
      #1 OUT_READY = ~OUT_READY;
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stalls and READY.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(OUT_VALID), 64'd1);
        chk("stall_data", DATA_OUT, prev_data);
      end
      if (OUT_VALID) begin
        vcycles++;
        chk("ready_low_in_emit", 64'(READY), 64'd0);
      end
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h expected none", DATA_OUT);
        end else begin
          chk("data_out", DATA_OUT, exp_q.pop_front());
        end
        xfers++;
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = DATA_OUT;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    RESET     = 1'b1;
    ENABLE    = 1'b0;
    DATA_IN   = '0;
    OUT_READY = 1'b1;
    #12;
    chk("rst_ready", 64'(READY), 64'd0);
    chk("rst_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_data", DATA_OUT, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", 64'(READY), 64'd1);

    // Basic row with OUT_READY held high, plus latency and output count.
    vcycles = 0;
    push_row(A, B, C, D, E, F, G, H);
    send(v4(A, B, C, D));
    send(v4(E, F, G, H));
    @(negedge CLK);
    chk("lat_valid_edge1", 64'(OUT_VALID), 64'd0);
    chk("lat_ready_edge1", 64'(READY), 64'd0);
    @(negedge CLK);
    chk("lat_valid_edge2", 64'(OUT_VALID), 64'd1);
    wait_done();
    chk("emit_cycles", 64'(vcycles), 64'd8);

    // Same row under OUT_READY toggling every cycle.
    toggle = 1'b1;
    push_row(A, B, C, D, E, F, G, H);
    send(v4(A, B, C, D));
    send(v4(E, F, G, H));
    wait_done();
    toggle = 1'b0;
    @(posedge CLK);
    #2 OUT_READY = 1'b1;

    // ENABLE held with junk data during EMIT must be ignored.
    push_row(H, G, F, E, D, C, B, A);
    send(v4(H, G, F, E));
    send(v4(D, C, B, A));
    ENABLE = 1'b1;
    t = 0;
    while (!READY && t < 300) begin
      DATA_IN = {$urandom, $urandom};
      @(negedge CLK);
      t++;
    end
    push_row(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707, 16'h0808);
    send(v4(16'h0101, 16'h0202, 16'h0303, 16'h0404));
    send(v4(16'h0505, 16'h0606, 16'h0707, 16'h0808));
    wait_done();

    // Reset after the fourth output, then a fresh row.
    xfers = 0;
    push_row(A, B, C, D, E, F, G, H);
    send(v4(A, B, C, D));
    send(v4(E, F, G, H));
    t = 0;
    while (xfers < 4 && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk("reached_fourth_output", 64'(xfers), 64'd4);
    @(posedge CLK);
    #2 RESET = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_valid", 64'(OUT_VALID), 64'd0);
    chk("midrst_data", DATA_OUT, 64'd0);
    chk("midrst_ready", 64'(READY), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("ready_after_midrst", 64'(READY), 64'd1);
    push_row(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    send(v4(16'd1, 16'd2, 16'd3, 16'd4));
    send(v4(16'd5, 16'd6, 16'd7, 16'd8));
    wait_done();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
